// File: rtl/deparser_do_deparsing.sv
// Deparser: writes processed PHV containers back into the original header
// bytes. One deparse action is applied per clock, so a later action that
// touches the same byte overwrites an earlier one (action 9 wins).
//
// Handshakes: a transfer happens on a rising axis_clk edge where valid and
// ready are both high. Once valid is raised, the payload is held stable
// until that edge. The upstream side may hold in_valid high while in_ready
// is low.
module deparser_do_deparsing #(
  parameter int C_AXIS_DATA_WIDTH  = 512,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_SEGS         = 2,
  parameter int PKT_HDR_LEN        = 1024,
  parameter int C_PARSER_RAM_WIDTH = 160
) (
  input  logic                                    axis_clk,
  input  logic                                    aresetn,
  input  logic [PKT_HDR_LEN-1:0]                  phv_in,
  input  logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] segs_in,
  input  logic [C_PARSER_RAM_WIDTH-1:0]           bram_in,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  output logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] segs_out,
  output logic [C_AXIS_TUSER_WIDTH-1:0]           tuser_out,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [7:0]                              act_err_cnt
);

  localparam int SEG_W     = C_NUM_SEGS * C_AXIS_DATA_WIDTH;
  localparam int HDR_BYTES = SEG_W / 8;
  localparam int NUM_ACTS  = 10;

  // Container bases inside the PHV.
  localparam int BASE_2B = 256;
  localparam int BASE_4B = 384;
  localparam int BASE_6B = 640;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DEPARSE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Working copies captured at accept time.
  logic [PKT_HDR_LEN-1:BASE_2B]    phv_c;
  logic [C_PARSER_RAM_WIDTH-1:0]   bram_r;
  logic [C_AXIS_TUSER_WIDTH-1:0]   tuser_r;
  logic [7:0]                      work [HDR_BYTES];
  logic [SEG_W-1:0]                work_flat;
  logic [3:0]                      act_idx;

  // Decoded current action.
  logic [15:0] act;
  logic        act_vld;
  logic [2:0]  act_cidx;
  logic [1:0]  act_type;
  logic [6:0]  act_off;
  logic [2:0]  act_len;
  logic [7:0]  act_end;
  logic        act_live;
  logic        act_write;
  logic        act_err;
  logic [47:0] val48;
  logic [15:0] c2;
  logic [31:0] c4;
  logic [47:0] c6;

  logic accept;
  logic unused_bits;

  // Metadata above the tuser field and the action's top bits are not used.
  assign unused_bits = &{1'b0, phv_in[255:C_AXIS_TUSER_WIDTH], act[15:13]};

  // Ready only in IDLE, and never while reset is held.
  assign in_ready = aresetn && (state == IDLE);
  assign accept   = in_ready && in_valid;

  // Pick and decode the action addressed by act_idx; action j lives at
  // bram[(9-j)*16 +: 16].
  always_comb begin
    act      = bram_r[(NUM_ACTS - 1 - int'(act_idx))*16 +: 16];
    act_vld  = act[0];
    act_cidx = act[3:1];
    act_type = act[5:4];
    act_off  = act[12:6];
    c2       = phv_c[BASE_2B + 16*int'(act_cidx) +: 16];
    c4       = phv_c[BASE_4B + 32*int'(act_cidx) +: 32];
    c6       = phv_c[BASE_6B + 48*int'(act_cidx) +: 48];
    act_len  = 3'd0;
    val48    = 48'd0;
    case (act_type)
      2'b01: begin act_len = 3'd2; val48 = {c2, 32'd0}; end
      2'b10: begin act_len = 3'd4; val48 = {c4, 16'd0}; end
      2'b11: begin act_len = 3'd6; val48 = c6;          end
      default: begin act_len = 3'd0; val48 = 48'd0;     end
    endcase
    act_end   = {1'b0, act_off} + {5'd0, act_len};
    act_live  = (state == DEPARSE) && act_vld && (act_type != 2'b00);
    act_write = act_live && (act_end <= 8'(HDR_BYTES));
    act_err   = act_live && (act_end >  8'(HDR_BYTES));
  end

  // Flatten the working byte array into wire order (byte k at [8k+:8]).
  always_comb begin
    work_flat = '0;
    for (int k = 0; k < HDR_BYTES; k++) begin
      work_flat[8*k +: 8] = work[k];
    end
  end

  // State register.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: accept, ten action cycles, then hold until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DEPARSE;
      DEPARSE: if (act_idx == 4'(NUM_ACTS - 1)) state_nxt = OUTPUT;
      OUTPUT:  if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the PHV containers, actions and tuser on accept.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      phv_c   <= '0;
      bram_r  <= '0;
      tuser_r <= '0;
    end else if (accept) begin
      phv_c   <= phv_in[PKT_HDR_LEN-1:BASE_2B];
      bram_r  <= bram_in;
      tuser_r <= phv_in[C_AXIS_TUSER_WIDTH-1:0];
    end
  end

  // Action index walks 0..9 through DEPARSE and rewinds afterwards.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      act_idx <= '0;
    end else if (accept) begin
      act_idx <= '0;
    end else if (state == DEPARSE) begin
      if (act_idx == 4'(NUM_ACTS - 1)) act_idx <= '0;
      else                             act_idx <= act_idx + 4'd1;
    end
  end

  // Header buffer: load on accept, then overwrite len bytes MSB-first.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < HDR_BYTES; k++) work[k] <= 8'd0;
    end else if (accept) begin
      for (int k = 0; k < HDR_BYTES; k++) work[k] <= segs_in[8*k +: 8];
    end else if (act_write) begin
      for (int m = 0; m < 6; m++) begin
        if (m < int'(act_len)) work[act_off + 7'(m)] <= val48[47 - 8*m -: 8];
      end
    end
  end

  // Saturating count of actions skipped for running past the header end.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn)                         act_err_cnt <= 8'd0;
    else if (act_err && act_err_cnt != 8'hFF) act_err_cnt <= act_err_cnt + 8'd1;
  end

  // Output register: load once on entering OUTPUT, hold until taken.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      segs_out  <= '0;
      tuser_out <= '0;
      out_valid <= 1'b0;
    end else if (state == OUTPUT) begin
      if (!out_valid) begin
        segs_out  <= work_flat;
        tuser_out <= tuser_r;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_deparser_do_deparsing.sv
// Directed bench for deparser_do_deparsing with a queue-based scoreboard.
module tb_deparser_do_deparsing;

  localparam int SEG_W = 1024;

  logic              axis_clk;
  logic              aresetn;
  logic [1023:0]     phv_in;
  logic [SEG_W-1:0]  segs_in;
  logic [159:0]      bram_in;
  logic              in_valid;
  logic              in_ready;
  logic [SEG_W-1:0]  segs_out;
  logic [127:0]      tuser_out;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        act_err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [SEG_W-1:0] exp_q[$];
  logic [127:0]     exp_tu_q[$];

  deparser_do_deparsing dut (
    .axis_clk    (axis_clk),
    .aresetn     (aresetn),
    .phv_in      (phv_in),
    .segs_in     (segs_in),
    .bram_in     (bram_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .segs_out    (segs_out),
    .tuser_out   (tuser_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .act_err_cnt (act_err_cnt)
  );

  // Clock / reset block
  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Action word composed from its fields: {3'b0, off, type, idx, valid}.
  function automatic logic [15:0] mk_act(input logic v, input logic [2:0] idx,
                                         input logic [1:0] typ, input logic [6:0] off);
    return {3'b000, off, typ, idx, v};
  endfunction

  function automatic logic [SEG_W-1:0] inc_segs();
    logic [SEG_W-1:0] s;
    for (int k = 0; k < 128; k++) s[8*k +: 8] = 8'(k);
    return s;
  endfunction

  // Driver: present one header and complete the in_valid/in_ready handshake.
  task automatic send_hdr(input logic [1023:0] phv, input logic [SEG_W-1:0] segs,
                          input logic [159:0] bram);
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      @(posedge axis_clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    phv_in   = phv;
    segs_in  = segs;
    bram_in  = bram;
    in_valid = 1'b1;
    @(posedge axis_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_hdr(input logic [SEG_W-1:0] e, input logic [127:0] tu);
    exp_q.push_back(e);
    exp_tu_q.push_back(tu);
  endtask

  // Wait until every expected header has been delivered.
  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 400) begin
      @(posedge axis_clk); #1;
      n++;
    end
    check("drain_timeout", 128'(exp_q.size()), 128'd0);
  endtask

  // Scoreboard monitor: compare on each accepted output beat.
  always @(negedge axis_clk) begin
    if (aresetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_out: got out_valid 1 expected no output");
      end else begin
        logic [SEG_W-1:0] e;
        logic [127:0]     tu;
        int first;
        e  = exp_q.pop_front();
        tu = exp_tu_q.pop_front();
        first = -1;
        for (int k = 0; k < 128; k++)
          if (first < 0 && segs_out[8*k +: 8] !== e[8*k +: 8]) first = k;
        n_tests++;
        if (first >= 0) begin
          n_fail++;
          $display("FAIL segs_out byte %0d: got %02h expected %02h",
                   first, segs_out[8*first +: 8], e[8*first +: 8]);
        end
        check("tuser_out", tuser_out, tu);
      end
    end
  end

  initial begin
    logic [1023:0]    phv;
    logic [SEG_W-1:0] base, e;
    logic [159:0]     bram;
    int               n;

    aresetn   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    phv_in    = '0;
    segs_in   = '0;
    bram_in   = '0;
    base      = inc_segs();

    // Reset state
    repeat (3) @(posedge axis_clk);
    #1;
    check("rst_in_ready",  128'(in_ready),    128'd0);
    check("rst_out_valid", 128'(out_valid),   128'd0);
    check("rst_segs_zero", 128'(|segs_out),   128'd0);
    check("rst_tuser",     tuser_out,         128'd0);
    check("rst_err_cnt",   128'(act_err_cnt), 128'd0);
    aresetn = 1'b1;
    @(posedge axis_clk); #1;
    check("idle_in_ready", 128'(in_ready), 128'd1);

    // 1: all actions invalid -> pass-through, latency 11
    phv = '0;
    phv[127:0] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    expect_hdr(base, phv[127:0]);
    send_hdr(phv, base, '0);
    repeat (10) @(posedge axis_clk);
    #1;
    check("lat_before", 128'(out_valid), 128'd0);
    check("busy_ready", 128'(in_ready),  128'd0);
    @(posedge axis_clk); #1;
    check("lat_rise",   128'(out_valid), 128'd1);
    drain();
    check("err_idle", 128'(act_err_cnt), 128'd0);

    // 2: 2B container 0 = AABB at offset 12
    phv = '0;
    phv[256 +: 16] = 16'hAABB;
    phv[127:0] = 128'h5;
    bram = '0;
    bram[9*16 +: 16] = mk_act(1'b1, 3'd0, 2'b01, 7'd12);
    e = base;
    e[8*12 +: 8] = 8'hAA;
    e[8*13 +: 8] = 8'hBB;
    expect_hdr(e, 128'h5);
    send_hdr(phv, base, bram);
    drain();

    // 3: 6B[2] at 0, then 4B[1] at 2 overwrites bytes 2..5
    phv = '0;
    phv[640 + 2*48 +: 48] = 48'h1122_3344_5566;
    phv[384 + 1*32 +: 32] = 32'hDEAD_BEEF;
    phv[127:0] = 128'hCAFE;
    bram = '0;
    bram[(9-1)*16 +: 16] = mk_act(1'b1, 3'd2, 2'b11, 7'd0);
    bram[(9-5)*16 +: 16] = mk_act(1'b1, 3'd1, 2'b10, 7'd2);
    e = base;
    e[8*0 +: 8] = 8'h11; e[8*1 +: 8] = 8'h22;
    e[8*2 +: 8] = 8'hDE; e[8*3 +: 8] = 8'hAD;
    e[8*4 +: 8] = 8'hBE; e[8*5 +: 8] = 8'hEF;
    expect_hdr(e, 128'hCAFE);
    send_hdr(phv, base, bram);
    drain();
    check("err_after_overlap", 128'(act_err_cnt), 128'd0);

    // 4: 4B at 126 is out of range; 2B at 126 just fits
    phv = '0;
    phv[384 +: 32] = 32'h9999_9999;
    phv[256 + 3*16 +: 16] = 16'hC0DE;
    bram = '0;
    bram[(9-3)*16 +: 16] = mk_act(1'b1, 3'd0, 2'b10, 7'd126);
    bram[(9-4)*16 +: 16] = mk_act(1'b1, 3'd3, 2'b01, 7'd126);
    e = base;
    e[8*126 +: 8] = 8'hC0;
    e[8*127 +: 8] = 8'hDE;
    expect_hdr(e, 128'h0);
    send_hdr(phv, base, bram);
    drain();
    check("err_one", 128'(act_err_cnt), 128'd1);

    // 5: 300 more out-of-range actions -> counter saturates at 255
    phv = '0;
    bram = '0;
    for (int j = 0; j < 10; j++) bram[j*16 +: 16] = mk_act(1'b1, 3'd0, 2'b10, 7'd126);
    for (int h = 0; h < 10; h++) begin
      expect_hdr(base, 128'h0);
      send_hdr(phv, base, bram);
    end
    drain();
    check("err_101", 128'(act_err_cnt), 128'd101);
    for (int h = 0; h < 20; h++) begin
      expect_hdr(base, 128'h0);
      send_hdr(phv, base, bram);
    end
    drain();
    check("err_sat", 128'(act_err_cnt), 128'd255);

    // 6: backpressure for 20 cycles
    out_ready = 1'b0;
    phv = '0;
    phv[256 +: 16] = 16'h1234;
    phv[127:0] = 128'h77;
    bram = '0;
    bram[9*16 +: 16] = mk_act(1'b1, 3'd0, 2'b01, 7'd40);
    e = base;
    e[8*40 +: 8] = 8'h12;
    e[8*41 +: 8] = 8'h34;
    expect_hdr(e, 128'h77);
    send_hdr(phv, base, bram);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge axis_clk); #1;
      n++;
    end
    check("bp_valid_seen", 128'(out_valid), 128'd1);
    for (int c = 0; c < 20; c++) begin
      @(posedge axis_clk); #1;
      check("bp_valid_hold", 128'(out_valid), 128'd1);
      check("bp_ready_low",  128'(in_ready),  128'd0);
      check("bp_segs_hold",  128'(segs_out === e), 128'd1);
    end
    out_ready = 1'b1;
    @(posedge axis_clk); #1;
    check("bp_valid_drop", 128'(out_valid), 128'd0);
    check("bp_ready_back", 128'(in_ready),  128'd1);
    check("bp_queue_done", 128'(exp_q.size()), 128'd0);

    // 7: reset in the middle of DEPARSE drops the header
    phv = '0;
    phv[256 +: 16] = 16'h5A5A;
    bram = '0;
    bram[9*16 +: 16] = mk_act(1'b1, 3'd0, 2'b01, 7'd0);
    send_hdr(phv, base, bram);
    repeat (4) @(posedge axis_clk);
    #2;
    aresetn = 1'b0;
    #1;
    check("mid_rst_valid", 128'(out_valid),   128'd0);
    check("mid_rst_segs",  128'(|segs_out),   128'd0);
    check("mid_rst_ready", 128'(in_ready),    128'd0);
    check("mid_rst_err",   128'(act_err_cnt), 128'd0);
    repeat (2) @(posedge axis_clk);
    #1;
    aresetn = 1'b1;
    repeat (15) @(posedge axis_clk);
    #1;
    check("mid_rst_no_out", 128'(out_valid), 128'd0);

    phv = '0;
    phv[256 + 7*16 +: 16] = 16'hBEEF;
    phv[127:0] = 128'h42;
    bram = '0;
    bram[0 +: 16] = mk_act(1'b1, 3'd7, 2'b01, 7'd100);
    e = base;
    e[8*100 +: 8] = 8'hBE;
    e[8*101 +: 8] = 8'hEF;
    expect_hdr(e, 128'h42);
    send_hdr(phv, base, bram);
    drain();

    check("final_queue", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
